// File: rtl/sync_filter_bank.sv
// ---------------------------------------------------------------------------
// sync_filter_bank
// Multi-bit synchronizer for asynchronous level inputs. Each channel runs
// through a STAGES-deep flop chain into dest_clk, an optional per-channel
// stability filter, and a registered edge detector.
//
// Ports:
//   dest_clk       in   1      sole clock, rising edge
//   dest_rstn      in   1      asynchronous active-low reset
//   source_signal  in   WIDTH  asynchronous level inputs
//   sync_signal    out  WIDTH  last synchronizer stage
//   filt_signal    out  WIDTH  filtered, accepted level
//   rise_pulse     out  WIDTH  one-cycle pulse on filt 0->1
//   fall_pulse     out  WIDTH  one-cycle pulse on filt 1->0
//   pending        out  WIDTH  candidate change under qualification
// ---------------------------------------------------------------------------
module sync_filter_bank #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      STAGES        = 2,
    parameter int unsigned      FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
    input  logic             dest_clk,
    input  logic             dest_rstn,
    input  logic [WIDTH-1:0] source_signal,
    output logic [WIDTH-1:0] sync_signal,
    output logic [WIDTH-1:0] filt_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] pending
);

    // A single flop cannot resolve metastability; refuse to build.
    if (STAGES < 2) begin : g_bad_stages
        $error("sync_filter_bank: STAGES must be at least 2");
    end

    // Synchronizer chain; nothing but flops between stages.
    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge dest_clk or negedge dest_rstn) begin
        if (!dest_rstn) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= source_signal;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign sync_signal = stage_q[STAGES-1];

    // Value filt_signal will hold after the next edge; feeds the edge detector.
    logic [WIDTH-1:0] filt_next;

    if (FILTER_CYCLES == 0) begin : g_bypass
        // No qualification: the filtered level is the synchronized level.
        assign filt_signal = sync_signal;
        assign filt_next   = stage_q[STAGES-2];
        assign pending     = '0;
    end else begin : g_filter
        localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

        logic [WIDTH-1:0] filt_q;
        logic [WIDTH-1:0] filt_d;
        logic [CNT_W-1:0] cnt_q [WIDTH];
        logic [CNT_W-1:0] cnt_d [WIDTH];

        // Per-channel qualification: a differing level must persist
        // FILTER_CYCLES consecutive edges; any return to filt restarts it.
        always_comb begin
            filt_d = filt_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_d[i] = '0;
                if (sync_signal[i] != filt_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        filt_d[i] = sync_signal[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge dest_clk or negedge dest_rstn) begin
            if (!dest_rstn) begin
                filt_q <= RESET_VAL;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                filt_q <= filt_d;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end

        // pending is a pure decode of the counter registers.
        always_comb begin
            pending = '0;
            for (int i = 0; i < WIDTH; i++) begin
                pending[i] = (cnt_q[i] != '0);
            end
        end

        assign filt_signal = filt_q;
        assign filt_next   = filt_d;
    end

    // Registered edge detect: pulse coincides with the first cycle of the new level.
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    always_ff @(posedge dest_clk or negedge dest_rstn) begin
        if (!dest_rstn) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= filt_next & ~filt_signal;
            fall_q <= ~filt_next & filt_signal;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_sync_filter_bank.sv
// ---------------------------------------------------------------------------
// tb_sync_filter_bank
// Self-checking bench for sync_filter_bank. Four instances share clock,
// reset and source: main (S=2,F=4), reset-value (S=2,F=4,RV=A5),
// bypass (S=3,F=0) and single-cycle filter (S=2,F=1).
// ---------------------------------------------------------------------------
module tb_sync_filter_bank;

    logic       clk;
    logic       rst_n;
    logic [7:0] src;

    logic [7:0] m_sync, m_filt, m_rise, m_fall, m_pend;
    logic [7:0] r_sync, r_filt, r_rise, r_fall, r_pend;
    logic [7:0] b_sync, b_filt, b_rise, b_fall, b_pend;
    logic [7:0] f_sync, f_filt, f_rise, f_fall, f_pend;

    int n_cmp = 0;
    int n_err = 0;

    sync_filter_bank #(.WIDTH(8), .STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(8'h00)) u_main (
        .dest_clk(clk), .dest_rstn(rst_n), .source_signal(src),
        .sync_signal(m_sync), .filt_signal(m_filt), .rise_pulse(m_rise),
        .fall_pulse(m_fall), .pending(m_pend));

    sync_filter_bank #(.WIDTH(8), .STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(8'hA5)) u_rv (
        .dest_clk(clk), .dest_rstn(rst_n), .source_signal(src),
        .sync_signal(r_sync), .filt_signal(r_filt), .rise_pulse(r_rise),
        .fall_pulse(r_fall), .pending(r_pend));

    sync_filter_bank #(.WIDTH(8), .STAGES(3), .FILTER_CYCLES(0), .RESET_VAL(8'h00)) u_byp (
        .dest_clk(clk), .dest_rstn(rst_n), .source_signal(src),
        .sync_signal(b_sync), .filt_signal(b_filt), .rise_pulse(b_rise),
        .fall_pulse(b_fall), .pending(b_pend));

    sync_filter_bank #(.WIDTH(8), .STAGES(2), .FILTER_CYCLES(1), .RESET_VAL(8'h00)) u_f1 (
        .dest_clk(clk), .dest_rstn(rst_n), .source_signal(src),
        .sync_signal(f_sync), .filt_signal(f_filt), .rise_pulse(f_rise),
        .fall_pulse(f_fall), .pending(f_pend));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  src;
        int unsigned hold;
        logic [7:0]  exp_filt;
    } vec_t;

    typedef struct {
        logic [7:0] filt;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    vec_t tbl [11];
    exp_t q_main [$];
    exp_t q_byp  [$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge and sample shortly after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sel(input bit c, input logic [7:0] v);
        return c ? v : 8'h00;
    endfunction

    // Drive bit3 high for len cycles from a quiet all-zero state and check every edge.
    task automatic glitch(input int len);
        bit acc;
        acc = (len >= 4);
        src = 8'h08;
        for (int k = 0; k < 12; k++) begin
            if (k == len) src = 8'h00;
            step();
            chk($sformatf("g%0d_m_sync_k%0d", len, k), m_sync, sel(k >= 1 && k <= len, 8'h08));
            if (acc) begin
                chk($sformatf("g%0d_m_filt_k%0d", len, k), m_filt, sel(k >= 5 && k <= 8, 8'h08));
                chk($sformatf("g%0d_m_pend_k%0d", len, k), m_pend,
                    sel((k >= 2 && k <= 4) || (k >= 6 && k <= 8), 8'h08));
                chk($sformatf("g%0d_m_rise_k%0d", len, k), m_rise, sel(k == 5, 8'h08));
                chk($sformatf("g%0d_m_fall_k%0d", len, k), m_fall, sel(k == 9, 8'h08));
            end else begin
                chk($sformatf("g%0d_m_filt_k%0d", len, k), m_filt, 8'h00);
                chk($sformatf("g%0d_m_pend_k%0d", len, k), m_pend, sel(k >= 2 && k <= len + 1, 8'h08));
                chk($sformatf("g%0d_m_rise_k%0d", len, k), m_rise, 8'h00);
                chk($sformatf("g%0d_m_fall_k%0d", len, k), m_fall, 8'h00);
            end
            chk($sformatf("g%0d_f1_filt_k%0d", len, k), f_filt, sel(k >= 2 && k <= len + 1, 8'h08));
            chk($sformatf("g%0d_f1_rise_k%0d", len, k), f_rise, sel(k == 2, 8'h08));
            chk($sformatf("g%0d_f1_fall_k%0d", len, k), f_fall, sel(k == len + 2, 8'h08));
            chk($sformatf("g%0d_f1_pend_k%0d", len, k), f_pend, 8'h00);
            chk($sformatf("g%0d_b_sync_k%0d", len, k), b_sync, sel(k >= 2 && k <= len + 1, 8'h08));
            chk($sformatf("g%0d_b_filt_k%0d", len, k), b_filt, sel(k >= 2 && k <= len + 1, 8'h08));
            chk($sformatf("g%0d_b_rise_k%0d", len, k), b_rise, sel(k == 2, 8'h08));
            chk($sformatf("g%0d_b_fall_k%0d", len, k), b_fall, sel(k == len + 2, 8'h08));
            chk($sformatf("g%0d_b_pend_k%0d", len, k), b_pend, 8'h00);
        end
        repeat (4) step();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] prev_src;
        logic [7:0] prev_exp;
        exp_t       e;

        tbl[0]  = '{8'h01, 8, 8'h01};
        tbl[1]  = '{8'h03, 8, 8'h03};
        tbl[2]  = '{8'h0B, 3, 8'h03};
        tbl[3]  = '{8'h03, 8, 8'h03};
        tbl[4]  = '{8'h41, 8, 8'h41};
        tbl[5]  = '{8'hC0, 8, 8'hC0};
        tbl[6]  = '{8'h3C, 8, 8'h3C};
        for (int r = 7; r < 10; r++) begin
            tbl[r].src      = 8'($urandom);
            tbl[r].hold     = 8;
            tbl[r].exp_filt = tbl[r].src;
        end
        tbl[10] = '{8'h00, 8, 8'h00};

        // Reset held with a busy source.
        rst_n = 1'b0;
        src   = 8'hFF;
        repeat (3) step();
        chk("rst_rv_sync", r_sync, 8'hA5);
        chk("rst_rv_filt", r_filt, 8'hA5);
        chk("rst_rv_rise", r_rise, 8'h00);
        chk("rst_rv_fall", r_fall, 8'h00);
        chk("rst_rv_pend", r_pend, 8'h00);
        chk("rst_m_sync",  m_sync, 8'h00);
        chk("rst_m_filt",  m_filt, 8'h00);
        chk("rst_b_filt",  b_filt, 8'h00);

        // Release with source still FF: full latency from the reset value.
        #3 rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("rel_rv_sync_k%0d", k), r_sync, (k >= 1) ? 8'hFF : 8'hA5);
            chk($sformatf("rel_rv_filt_k%0d", k), r_filt, (k >= 5) ? 8'hFF : 8'hA5);
            chk($sformatf("rel_rv_rise_k%0d", k), r_rise, sel(k == 5, 8'h5A));
            chk($sformatf("rel_rv_fall_k%0d", k), r_fall, 8'h00);
            chk($sformatf("rel_rv_pend_k%0d", k), r_pend, sel(k >= 2 && k <= 4, 8'h5A));
            chk($sformatf("rel_m_filt_k%0d", k),  m_filt, sel(k >= 5, 8'hFF));
            chk($sformatf("rel_m_rise_k%0d", k),  m_rise, sel(k == 5, 8'hFF));
            chk($sformatf("rel_b_filt_k%0d", k),  b_filt, sel(k >= 2, 8'hFF));
            chk($sformatf("rel_b_rise_k%0d", k),  b_rise, sel(k == 2, 8'hFF));
            chk($sformatf("rel_f1_filt_k%0d", k), f_filt, sel(k >= 2, 8'hFF));
        end
        src = 8'h00;
        repeat (12) step();

        // Table-driven vectors with scoreboard queues.
        prev_src = 8'h00;
        prev_exp = 8'h00;
        for (int r = 0; r < 11; r++) begin
            src    = tbl[r].src;
            e.filt = tbl[r].exp_filt;
            e.rise = tbl[r].exp_filt & ~prev_exp;
            e.fall = ~tbl[r].exp_filt & prev_exp;
            q_main.push_back(e);
            e.filt = tbl[r].src;
            e.rise = tbl[r].src & ~prev_src;
            e.fall = ~tbl[r].src & prev_src;
            q_byp.push_back(e);
            for (int j = 0; j < int'(tbl[r].hold); j++) begin
                step();
                chk($sformatf("v%0d_m_rise_j%0d", r, j), m_rise, sel(j == 5, q_main[0].rise));
                chk($sformatf("v%0d_m_fall_j%0d", r, j), m_fall, sel(j == 5, q_main[0].fall));
                chk($sformatf("v%0d_b_rise_j%0d", r, j), b_rise, sel(j == 2, q_byp[0].rise));
                chk($sformatf("v%0d_b_fall_j%0d", r, j), b_fall, sel(j == 2, q_byp[0].fall));
            end
            e = q_main.pop_front();
            chk($sformatf("v%0d_m_filt", r), m_filt, e.filt);
            if (tbl[r].hold >= 8) chk($sformatf("v%0d_m_pend", r), m_pend, 8'h00);
            e = q_byp.pop_front();
            chk($sformatf("v%0d_b_filt", r), b_filt, e.filt);
            chk($sformatf("v%0d_b_pend", r), b_pend, 8'h00);
            prev_src = tbl[r].src;
            prev_exp = tbl[r].exp_filt;
        end
        repeat (4) step();

        // Glitch shorter than the filter, then exactly as long.
        glitch(3);
        glitch(4);

        // Reset mid-qualification, asserted between edges.
        src = 8'h01;
        repeat (4) step();
        chk("mq_m_pend_before", m_pend, 8'h01);
        chk("mq_m_sync_before", m_sync, 8'h01);
        #3 rst_n = 1'b0;
        #1;
        chk("mq_async_m_sync", m_sync, 8'h00);
        chk("mq_async_m_pend", m_pend, 8'h00);
        chk("mq_async_b_filt", b_filt, 8'h00);
        chk("mq_async_f1_filt", f_filt, 8'h00);
        chk("mq_async_rv_sync", r_sync, 8'hA5);
        chk("mq_async_rv_filt", r_filt, 8'hA5);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("mq_m_sync_k%0d", k), m_sync, sel(k >= 1, 8'h01));
            chk($sformatf("mq_m_filt_k%0d", k), m_filt, sel(k >= 5, 8'h01));
            chk($sformatf("mq_m_rise_k%0d", k), m_rise, sel(k == 5, 8'h01));
            chk($sformatf("mq_m_pend_k%0d", k), m_pend, sel(k >= 2 && k <= 4, 8'h01));
            chk($sformatf("mq_b_rise_k%0d", k), b_rise, sel(k == 2, 8'h01));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_filter_bank.md
# sync_filter_bank

Parametrised multi-bit synchronizer for asynchronous level inputs. Each bit passes through a configurable-depth flip-flop chain into `dest_clk`, then through an optional per-bit stability filter (glitch/debounce), then an edge detector that produces single-cycle rise/fall pulses. It sits at the boundary where asynchronous status lines, pins or slow-domain levels enter the `dest_clk` domain. It replaces the fixed two-stage, unfiltered synchronizer where consumers need a deeper chain, glitch rejection or edge events.

## Interface
- `WIDTH`, 8, number of independent channels (≥1).
- `STAGES`, 2, synchronizer flop depth per channel (≥2; <2 is an elaboration error).
- `FILTER_CYCLES`, 4, consecutive cycles a new synchronized value must persist before it is accepted (0 = filter bypassed).
- `RESET_VAL`, {WIDTH{1'b0}}, reset value of every stage, `sync_signal` and `filt_signal`.

- `dest_clk`  in  1  sole clock; all state updates on its rising edge.
- `dest_rstn`  in  1  asynchronous, active-low reset.
- `source_signal`  in  WIDTH  asynchronous level inputs, one per channel.
- `sync_signal`  out  WIDTH  output of the last synchronizer stage.
- `filt_signal`  out  WIDTH  filtered, accepted level per channel.
- `rise_pulse`  out  WIDTH  one-cycle pulse on a 0→1 change of `filt_signal`.
- `fall_pulse`  out  WIDTH  one-cycle pulse on a 1→0 change of `filt_signal`.
- `pending`  out  WIDTH  channel has a candidate change being qualified (counter nonzero).

## Operation
- Sync chain: stage[0] samples `source_signal`; stage[k] ← stage[k-1]; `sync_signal` = stage[STAGES-1]. No logic between stages.
- Filter, per channel i, counter `cnt` of width clog2(FILTER_CYCLES+1), evaluated each edge:
  - sync[i] == filt[i]: cnt ← 0 (any partial qualification discarded).
  - sync[i] != filt[i] and cnt == FILTER_CYCLES-1: filt[i] ← sync[i], cnt ← 0.
  - otherwise: cnt ← cnt+1.
- FILTER_CYCLES = 0: no counters; `filt_signal` is a combinational copy of `sync_signal`; `pending` tied 0.
- FILTER_CYCLES = 1: filt follows sync with one cycle of lag; pending never asserts.
- Edges: registered; rise_pulse[i] ← next_filt[i] & ~filt[i]; fall_pulse[i] ← ~next_filt[i] & filt[i]. Each pulse is high exactly in the first cycle `filt_signal` shows the new value. With FILTER_CYCLES=0, next_filt = next stage[STAGES-1].
- `pending[i]` = (cnt[i] != 0), registered via cnt.
- Channels are fully independent; simultaneous changes on several bits qualify separately (no bus coherency; multi-bit values must be Gray-coded by the source).
- Reset asserted: all stages, `sync_signal`, `filt_signal` = RESET_VAL; all cnt = 0; pulses and `pending` = 0, immediately and asynchronously. Reset mid-qualification discards it. After release, a source differing from RESET_VAL is synchronized and filtered normally and produces a pulse.

## Timing
- Source change stable before edge t0 → `sync_signal` changes after edge t0+STAGES-1 (one extra cycle possible when setup at t0 is violated).
- `filt_signal` changes FILTER_CYCLES edges after `sync_signal` changes, so total latency is STAGES+FILTER_CYCLES edges (±1 metastability).
- A sync-level excursion lasting < FILTER_CYCLES cycles is rejected: no filt change, no pulse; `pending` is high during it.
- Pulse width is exactly 1 cycle. Minimum spacing between pulses on one channel is FILTER_CYCLES cycles (1 if bypassed).

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5, hold `dest_rstn`=0 with source=8'hFF → sync/filt=8'hA5, pulses/pending=0; assert reset asynchronously mid-cycle → outputs go to reset values without a clock edge.
- Latency: STAGES=2, F=4, bit0 0→1 set up before edge 0 → sync[0]=1 after edge 1, filt[0]=1 and rise_pulse[0]=1 after edge 5, rise_pulse[0]=0 after edge 6.
- Glitch: F=4, bit3 high for 3 cycles at sync → filt[3] stays 0, no pulse, pending[3]=1 for 3 cycles then 0; repeat with 4 cycles → filt[3]=1 with one rise_pulse.
- Fall plus independence: bits 1 and 6 toggle on the same edge in opposite directions → fall_pulse[1] and rise_pulse[6] in the same cycle; other bits stay quiet.
- Bypass and depth: STAGES=3, F=0 → filt == sync, pulse 3 edges after the source change, pending always 0; STAGES=1 → elaboration fails.
- Reset mid-qualification: F=4, reset at cnt=2 → cnt=0; after release with the source still changed, full 2+4-edge latency to filt.
